// File: rtl/uart_pkg.sv
// uart_pkg: shared types and helpers for the UART transmit path.
// Frame states, parity-type encodings and the parity helper used at word pop.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    // Widest legal data word; narrower words are zero-extended before use.
    localparam int MAX_WIDTH = 9;

    // Parity bit over the data word: even parity gives the plain XOR,
    // odd parity gives its complement. Zero-extension does not change it.
    function automatic logic calc_parity(input logic [MAX_WIDTH-1:0] data,
                                         input logic                 typ);
        logic p;
        p = ^data;
        case (typ)
            PAR_EVEN: p = ^data;
            PAR_ODD:  p = ~(^data);
        endcase
        return p;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: synchronous first-word-fall-through FIFO for the transmitter.
// Pointers carry one extra wrap bit so full and empty are told apart without
// a separate occupancy counter. Pushes when full and pops when empty are ignored.
module uart_tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rd_data = mem[rd_ptr[AW-1:0]];

    // Pointer advance; reset empties the queue by aligning the pointers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full)
                wr_ptr <= wr_ptr + PTR_ONE;
            if (pop && !empty)
                rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // Storage array, written at the current write slot.
    always_ff @(posedge clk) begin
        if (push && !full)
            mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/uart_tx_ext.sv
// uart_tx_ext: parametrised UART transmitter with valid/ready input.
// Frame: start, WIDTH data bits LSB first, optional parity, one or two stops.
// Build option UART_TX_FIFO_EN: DEPTH-entry FIFO in front of the frame engine;
// without it a single holding register queues one word behind the frame in flight.
module uart_tx_ext
    import uart_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int DIV_W = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] P_DATA,
    input  logic             data_valid,
    output logic             data_ready,
    input  logic             PAR_EN,
    input  logic             PAR_TYP,
    input  logic             STOP2,
    input  logic [DIV_W-1:0] DIV,
    output logic             TX_OUT,
    output logic             busy
);

    localparam int               IDX_W    = $clog2(WIDTH) + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

    if (WIDTH < 5 || WIDTH > MAX_WIDTH || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_param
        $error("uart_tx_ext: WIDTH must be 5..9 and DEPTH a power of two >= 2");
    end

    logic             push;
    logic             pop;
    logic             buf_empty;
    logic [WIDTH-1:0] buf_data;

    assign push = data_valid && data_ready;

`ifdef UART_TX_FIFO_EN
    logic buf_full;

    uart_tx_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (CLK),
        .rst     (RST),
        .push    (push),
        .wr_data (P_DATA),
        .pop     (pop),
        .rd_data (buf_data),
        .full    (buf_full),
        .empty   (buf_empty)
    );

    assign data_ready = !buf_full;
`else
    logic             hold_vld;
    logic [WIDTH-1:0] hold_data;

    // Single-word holding register; push and pop never coincide because a
    // push needs it empty and a pop needs it full.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            hold_vld  <= 1'b0;
            hold_data <= '0;
        end else if (push) begin
            hold_vld  <= 1'b1;
            hold_data <= P_DATA;
        end else if (pop) begin
            hold_vld  <= 1'b0;
        end
    end

    assign buf_empty  = !hold_vld;
    assign buf_data   = hold_data;
    assign data_ready = !hold_vld;
`endif

    tx_state_t        state_q, state_n;
    logic [WIDTH-1:0] shift_q, shift_n;
    logic [IDX_W-1:0] bit_idx_q, bit_idx_n;
    logic [DIV_W-1:0] timer_q, timer_n;
    logic [DIV_W-1:0] div_q, div_n;
    logic             stop_cnt_q, stop_cnt_n;
    logic             par_en_q, par_en_n;
    logic             stop2_q, stop2_n;
    logic             par_bit_q, par_bit_n;
    logic             tx_q, tx_n;
    logic             busy_q, busy_n;
    logic [DIV_W-1:0] div_load;
    logic             bit_end;

    // A divider of 0 behaves like 1, so the reload value never underflows.
    assign div_load = (DIV == '0) ? '0 : DIV - DIV_ONE;
    assign bit_end  = (timer_q == '0);

    // Frame state and all per-frame registers, including the registered line.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            bit_idx_q  <= '0;
            timer_q    <= '0;
            div_q      <= '0;
            stop_cnt_q <= 1'b0;
            par_en_q   <= 1'b0;
            stop2_q    <= 1'b0;
            par_bit_q  <= 1'b0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_n;
            shift_q    <= shift_n;
            bit_idx_q  <= bit_idx_n;
            timer_q    <= timer_n;
            div_q      <= div_n;
            stop_cnt_q <= stop_cnt_n;
            par_en_q   <= par_en_n;
            stop2_q    <= stop2_n;
            par_bit_q  <= par_bit_n;
            tx_q       <= tx_n;
            busy_q     <= busy_n;
        end
    end

    // Next-state and next-line logic; a pop latches word, parity and settings.
    always_comb begin
        state_n    = state_q;
        shift_n    = shift_q;
        bit_idx_n  = bit_idx_q;
        timer_n    = timer_q;
        div_n      = div_q;
        stop_cnt_n = stop_cnt_q;
        par_en_n   = par_en_q;
        stop2_n    = stop2_q;
        par_bit_n  = par_bit_q;
        tx_n       = tx_q;
        busy_n     = busy_q;
        pop        = 1'b0;

        if (state_q != IDLE)
            timer_n = bit_end ? div_q : timer_q - DIV_ONE;

        case (state_q)
            IDLE: pop = !buf_empty;
            START: begin
                if (bit_end) begin
                    state_n   = DATA;
                    bit_idx_n = '0;
                    tx_n      = shift_q[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_idx_q == LAST_IDX) begin
                        if (par_en_q) begin
                            state_n = PARITY;
                            tx_n    = par_bit_q;
                        end else begin
                            state_n    = STOP;
                            stop_cnt_n = 1'b0;
                            tx_n       = 1'b1;
                        end
                    end else begin
                        bit_idx_n = bit_idx_q + IDX_ONE;
                        shift_n   = shift_q >> 1;
                        tx_n      = shift_q[1];
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_n    = STOP;
                    stop_cnt_n = 1'b0;
                    tx_n       = 1'b1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (stop2_q && !stop_cnt_q) begin
                        stop_cnt_n = 1'b1;
                    end else if (!buf_empty) begin
                        pop = 1'b1;
                    end else begin
                        state_n = IDLE;
                        timer_n = '0;
                        tx_n    = 1'b1;
                        busy_n  = 1'b0;
                    end
                end
            end
            default: state_n = IDLE;
        endcase

        if (pop) begin
            state_n    = START;
            shift_n    = buf_data;
            bit_idx_n  = '0;
            stop_cnt_n = 1'b0;
            timer_n    = div_load;
            div_n      = div_load;
            par_en_n   = PAR_EN;
            stop2_n    = STOP2;
            par_bit_n  = calc_parity(MAX_WIDTH'(buf_data), PAR_TYP);
            tx_n       = 1'b0;
            busy_n     = 1'b1;
        end
    end

    assign TX_OUT = tx_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_uart_tx_ext.sv
// tb_uart_tx_ext: directed bench for uart_tx_ext (8-bit and 5-bit instances).
// Handles both builds of UART_TX_FIFO_EN for the buffer-specific steps.
module tb_uart_tx_ext;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  p_data8;
    logic        valid8, ready8, tx8, busy8;
    logic [4:0]  p_data5;
    logic        valid5, ready5, tx5, busy5;
    logic        par_en, par_typ, stop2;
    logic [15:0] div_in;

    int n_cmp  = 0;
    int n_mism = 0;

    always #5 clk = ~clk;

    uart_tx_ext #(.WIDTH(8), .DEPTH(4), .DIV_W(16)) dut8 (
        .CLK(clk), .RST(rst), .P_DATA(p_data8), .data_valid(valid8), .data_ready(ready8),
        .PAR_EN(par_en), .PAR_TYP(par_typ), .STOP2(stop2), .DIV(div_in),
        .TX_OUT(tx8), .busy(busy8)
    );

    uart_tx_ext #(.WIDTH(5), .DEPTH(4), .DIV_W(16)) dut5 (
        .CLK(clk), .RST(rst), .P_DATA(p_data5), .data_valid(valid5), .data_ready(ready5),
        .PAR_EN(par_en), .PAR_TYP(par_typ), .STOP2(stop2), .DIV(div_in),
        .TX_OUT(tx5), .busy(busy5)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mism++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer a word and return #1 after the edge that accepts it.
    task automatic push_word(input bit use5, input logic [7:0] d, input string tag);
        int guard = 0;
        if (use5) begin p_data5 = d[4:0]; valid5 = 1'b1; end
        else      begin p_data8 = d;      valid8 = 1'b1; end
        while (!(use5 ? ready5 : ready8) && guard < 500) begin
            tick();
            guard++;
        end
        check({tag, "_ready"}, use5 ? ready5 : ready8, 1);
        tick();
        valid5 = 1'b0;
        valid8 = 1'b0;
    endtask

    // Starting #1 after the edge where the start bit appeared, check every
    // clock of the frame, then the return to idle.
    task automatic run_frame(input bit use5, input logic [15:0] frame, input int nbits,
                             input int div, input string tag);
        int per = (div == 0) ? 1 : div;
        for (int i = 0; i < nbits; i++) begin
            for (int c = 0; c < per; c++) begin
                check($sformatf("%s_bit%0d", tag, i), use5 ? tx5 : tx8, frame[i]);
                check($sformatf("%s_busy%0d", tag, i), use5 ? busy5 : busy8, 1);
                tick();
            end
        end
        check({tag, "_end_busy"}, use5 ? busy5 : busy8, 0);
        check({tag, "_end_line"}, use5 ? tx5 : tx8, 1);
    endtask

    task automatic wait_idle8(input string tag);
        int guard = 0;
        while (busy8 && guard < 2000) begin
            tick();
            guard++;
        end
        check({tag, "_idle"}, busy8, 0);
    endtask

    initial begin
        logic [7:0] w;
        int         j;
        logic       exp_tx;

        rst = 1'b0; valid8 = 1'b0; valid5 = 1'b0; p_data8 = '0; p_data5 = '0;
        par_en = 1'b0; par_typ = 1'b0; stop2 = 1'b0; div_in = 16'd4;
        #1 rst = 1'b1;
        #1;
        check("rst_tx8", tx8, 1);
        check("rst_busy8", busy8, 0);
        check("rst_ready8", ready8, 1);
        check("rst_tx5", tx5, 1);
        check("rst_ready5", ready5, 1);
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // Basic 8N1 frame, DIV=4, 0xA5.
        push_word(0, 8'hA5, "basic");
        check("basic_not_yet", tx8, 1);
`ifdef UART_TX_FIFO_EN
        check("basic_ready_after_accept", ready8, 1);
`else
        check("basic_ready_after_accept", ready8, 0);
`endif
        tick();
        check("basic_latency", tx8, 0);
        run_frame(0, {6'b0, 1'b1, 8'hA5, 1'b0}, 10, 4, "basic");

        // Even parity on 0x07: three ones, parity bit 1.
        par_en = 1'b1; par_typ = 1'b0; div_in = 16'd2;
        push_word(0, 8'h07, "par_even");
        tick();
        run_frame(0, {5'b0, 1'b1, 1'b1, 8'h07, 1'b0}, 11, 2, "par_even");

        // Odd parity: bit 0; flipping PAR_TYP mid-frame must not matter.
        par_typ = 1'b1;
        push_word(0, 8'h07, "par_odd");
        tick();
        par_typ = 1'b0;
        run_frame(0, {5'b0, 1'b1, 1'b0, 8'h07, 1'b0}, 11, 2, "par_odd");

        // DIV=0 behaves as one clock per bit.
        par_en = 1'b0; div_in = 16'd0;
        push_word(0, 8'h3C, "div0");
        tick();
        run_frame(0, {6'b0, 1'b1, 8'h3C, 1'b0}, 10, 1, "div0");

        // DIV changed mid-frame applies to the next frame only.
        div_in = 16'd2;
        push_word(0, 8'h55, "divchg_a");
        tick();
        div_in = 16'd5;
        run_frame(0, {6'b0, 1'b1, 8'h55, 1'b0}, 10, 2, "divchg_a");
        push_word(0, 8'h0F, "divchg_b");
        tick();
        run_frame(0, {6'b0, 1'b1, 8'h0F, 1'b0}, 10, 5, "divchg_b");

        // Two stop bits on the 5-bit instance: 8 bits per frame.
        stop2 = 1'b1; div_in = 16'd3;
        push_word(1, 8'h16, "stop2_w5");
        tick();
        run_frame(1, {8'b0, 1'b1, 1'b1, 5'h16, 1'b0}, 8, 3, "stop2_w5");
        stop2 = 1'b0;

`ifdef UART_TX_FIFO_EN
        // Five back-to-back words into a 4-deep FIFO, DIV=1.
        div_in = 16'd1;
        valid8 = 1'b1;
        for (int c = 1; c <= 52; c++) begin
            if (c <= 5) begin
                p_data8 = 8'(c);
                check($sformatf("ff_offer%0d_ready", c), ready8, 1);
            end
            tick();
            if (c == 5) valid8 = 1'b0;
            if (c >= 5)
                check($sformatf("ff_ready_c%0d", c), ready8, (c <= 11) ? 0 : 1);
            if (c == 1) begin
                check("ff_c1_line", tx8, 1);
                check("ff_c1_busy", busy8, 0);
            end else if (c <= 51) begin
                j = c - 2;
                w = 8'(j / 10 + 1);
                if (j % 10 == 0)      exp_tx = 1'b0;
                else if (j % 10 == 9) exp_tx = 1'b1;
                else                  exp_tx = w[j % 10 - 1];
                check($sformatf("ff_line_c%0d", c), tx8, exp_tx);
                check($sformatf("ff_busy_c%0d", c), busy8, 1);
            end else begin
                check("ff_final_busy", busy8, 0);
                check("ff_final_line", tx8, 1);
            end
        end
`else
        // Holding register: one word behind the frame in flight, third held off.
        div_in = 16'd2;
        p_data8 = 8'h11; valid8 = 1'b1;
        check("hr_ready_idle", ready8, 1);
        tick();
        check("hr_ready_after_accept", ready8, 0);
        p_data8 = 8'h22;
        tick();
        check("hr_start1", tx8, 0);
        check("hr_ready_at_pop", ready8, 1);
        tick();
        check("hr_ready_second", ready8, 0);
        p_data8 = 8'h33;
        for (int k = 0; k < 18; k++) begin
            tick();
            check($sformatf("hr_held%0d", k), ready8, 0);
            check($sformatf("hr_busy%0d", k), busy8, 1);
        end
        check("hr_stop1_line", tx8, 1);
        tick();
        check("hr_b2b_start", tx8, 0);
        check("hr_b2b_busy", busy8, 1);
        check("hr_ready_pop2", ready8, 1);
        tick();
        valid8 = 1'b0;
        check("hr_ready_third", ready8, 0);
`endif
        wait_idle8("buf");

        // Reset during data bit 3 of 0x00 with a second word queued.
        div_in = 16'd4;
        push_word(0, 8'h00, "rst_a");
        tick();
        push_word(0, 8'h0F, "rst_b");
        repeat (16) tick();
        check("rst_mid_line_low", tx8, 0);
        rst = 1'b1;
        #1;
        check("rst_mid_line", tx8, 1);
        check("rst_mid_busy", busy8, 0);
        check("rst_mid_ready", ready8, 1);
        tick();
        rst = 1'b0;
        for (int k = 0; k < 60; k++) begin
            tick();
            check($sformatf("rst_quiet_line%0d", k), tx8, 1);
            check($sformatf("rst_quiet_busy%0d", k), busy8, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mism);
        $finish;
    end

endmodule
